// File: rtl/maxnet_input_loader.sv
// Collects four 32-bit IEEE 754 words into a set, strobes ldI once, then waits for done_in.
// Optional feature: define MAXNET_LOADER_SIGN_CLAMP_EN to store any negative-signed word as +0.0.
module maxnet_input_loader (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  output logic        in_ready,
  input  logic        done_in,
  output logic [31:0] inp1,
  output logic [31:0] inp2,
  output logic [31:0] inp3,
  output logic [31:0] inp4,
  output logic        ldI,
  output logic        busy,
  output logic [1:0]  cnt
);

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] slot_q [4];
  logic        accept;

`ifdef MAXNET_LOADER_SIGN_CLAMP_EN
  // Sign bit set covers negatives, -0.0 and negative NaNs alike.
  function automatic logic [31:0] store_word(input logic [31:0] w);
    return w[31] ? 32'h0000_0000 : w;
  endfunction
`else
  function automatic logic [31:0] store_word(input logic [31:0] w);
    return w;
  endfunction
`endif

  // Acceptance is decoded from state directly so in_ready never feeds back into itself.
  assign accept = rst && (state_q == COLLECT) && in_valid;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    in_ready = 1'b0;
    ldI      = 1'b0;
    busy     = 1'b0;
    case (state_q)
      COLLECT: begin
        in_ready = rst;
        if (accept) begin
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_d = ISSUE;
        end
      end
      ISSUE: begin
        ldI     = rst;
        busy    = 1'b1;
        state_d = WAIT;
      end
      WAIT: begin
        busy = 1'b1;
        if (done_in) state_d = COLLECT;
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= COLLECT;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Slots hold across ISSUE/WAIT and are only overwritten one at a time by later accepts.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) slot_q[i] <= 32'h0000_0000;
    end else if (accept) begin
      slot_q[cnt_q] <= store_word(in_data);
    end
  end

  assign inp1 = slot_q[0];
  assign inp2 = slot_q[1];
  assign inp3 = slot_q[2];
  assign inp4 = slot_q[3];
  assign cnt  = cnt_q;

endmodule

// File: tb/tb_maxnet_input_loader.sv
// Self-checking bench for maxnet_input_loader: directed scenarios plus random traffic vs a reference model.
module tb_maxnet_input_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        done_in;
  logic [31:0] inp1, inp2, inp3, inp4;
  logic        ldI;
  logic        busy;
  logic [1:0]  cnt;

  int n_tests = 0;
  int n_fail  = 0;

  maxnet_input_loader dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .done_in(done_in), .inp1(inp1), .inp2(inp2), .inp3(inp3), .inp4(inp4),
    .ldI(ldI), .busy(busy), .cnt(cnt)
  );

  always #5 clk = ~clk;

  // Reference model: slot contents, words in the current set, and an outstanding-set flag
  // with the number of cycles since the set completed.
  logic [31:0] m_inp [4];
  int          m_cnt;
  bit          m_out;
  int          m_age;
  logic [31:0] acc_q [$];
  int          n_ldi;

  function automatic logic [31:0] ref_store(input logic [31:0] w);
`ifdef MAXNET_LOADER_SIGN_CLAMP_EN
    if (w[31]) return 32'h0;
`endif
    return w;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_inp[i] = 32'h0;
    m_cnt = 0;
    m_out = 1'b0;
    m_age = 0;
    acc_q.delete();
  endtask

  // One clock cycle: drive inputs after the falling edge, check outputs, advance the model.
  task automatic cyc(input bit v, input logic [31:0] d, input bit dn, input bit r, output bit acc);
    bit e_ldi;
    @(negedge clk);
    in_valid = v; in_data = d; done_in = dn; rst = r;
    #1;
    e_ldi = r && m_out && (m_age == 0);
    check_eq("in_ready", in_ready, r && !m_out);
    check_eq("ldI", ldI, e_ldi);
    check_eq("busy", busy, m_out);
    check_eq("cnt", cnt, m_cnt);
    check_eq("inp1", inp1, m_inp[0]);
    check_eq("inp2", inp2, m_inp[1]);
    check_eq("inp3", inp3, m_inp[2]);
    check_eq("inp4", inp4, m_inp[3]);
    if (ldI) begin
      n_ldi++;
      check_eq("sb_size", acc_q.size(), 4);
      if (acc_q.size() >= 4) begin
        check_eq("sb_inp1", inp1, acc_q[0]);
        check_eq("sb_inp2", inp2, acc_q[1]);
        check_eq("sb_inp3", inp3, acc_q[2]);
        check_eq("sb_inp4", inp4, acc_q[3]);
      end
      acc_q.delete();
    end
    acc = r && v && !m_out;
    if (!r) begin
      model_reset();
    end else if (m_out) begin
      if (m_age >= 1 && dn) m_out = 1'b0;
      m_age++;
    end else if (v) begin
      m_inp[m_cnt] = ref_store(d);
      acc_q.push_back(ref_store(d));
      if (m_cnt == 3) begin
        m_cnt = 0;
        m_out = 1'b1;
        m_age = 0;
      end else begin
        m_cnt++;
      end
    end
  endtask

  task automatic do_reset();
    bit a;
    cyc(1'b0, 32'h0, 1'b0, 1'b0, a);
  endtask

  logic [31:0] words [5];
  logic [31:0] cwords [4];
  bit          acc;
  bit          hv;
  logic [31:0] hd;
  int          ldi_before;

  initial begin
    words  = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h41000000};
    cwords = '{32'hBF800000, 32'h3F800000, 32'h80000000, 32'h40000000};
    in_valid = 1'b0; in_data = 32'h0; done_in = 1'b0; rst = 1'b0;
    n_ldi = 0;
    @(posedge clk);
    @(posedge clk);
    model_reset();
    #1;
    check_eq("rst_in_ready", in_ready, 1'b0);
    check_eq("rst_cnt", cnt, 2'd0);
    check_eq("rst_busy", busy, 1'b0);

    // Basic load, done_in three cycles after ldI
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1'b1, words[i], 1'b0, 1'b1, acc);
    cyc(1'b0, 32'h0, 1'b0, 1'b1, acc);
    check_eq("basic_ldi_count", n_ldi, 1);
    cyc(1'b0, 32'h0, 1'b0, 1'b1, acc);
    cyc(1'b0, 32'h0, 1'b0, 1'b1, acc);
    cyc(1'b0, 32'h0, 1'b1, 1'b1, acc);
    cyc(1'b0, 32'h0, 1'b0, 1'b1, acc);
    check_eq("basic_inp1", inp1, 32'h3F800000);
    check_eq("basic_inp4", inp4, 32'h40800000);

    // Backpressure: fifth word held until after done_in
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1'b1, words[i], 1'b0, 1'b1, acc);
    acc = 1'b0;
    for (int i = 0; i < 10 && !acc; i++) cyc(1'b1, words[4], (i == 3), 1'b1, acc);
    check_eq("bp_accepted", acc, 1'b1);
    cyc(1'b0, 32'h0, 1'b0, 1'b1, acc);
    check_eq("bp_inp1", inp1, 32'h41000000);
    check_eq("bp_inp2", inp2, 32'h40000000);

    // Gapped input
    do_reset();
    ldi_before = n_ldi;
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, words[i], 1'b0, 1'b1, acc);
      cyc(1'b0, 32'h0, 1'b0, 1'b1, acc);
    end
    check_eq("gap_ldi", n_ldi - ldi_before, 1);
    cyc(1'b0, 32'h0, 1'b1, 1'b1, acc);
    cyc(1'b0, 32'h0, 1'b0, 1'b1, acc);

    // Mid-collect reset discards the partial set
    cyc(1'b1, words[0], 1'b0, 1'b1, acc);
    cyc(1'b1, words[1], 1'b0, 1'b1, acc);
    cyc(1'b1, words[2], 1'b0, 1'b0, acc);
    ldi_before = n_ldi;
    for (int i = 0; i < 3; i++) cyc(1'b0, 32'h0, 1'b0, 1'b1, acc);
    check_eq("mid_rst_no_ldi", n_ldi - ldi_before, 0);
    check_eq("mid_rst_inp1", inp1, 32'h0);

    // Early done_in during ISSUE only
    for (int i = 0; i < 4; i++) cyc(1'b1, words[i], 1'b0, 1'b1, acc);
    cyc(1'b0, 32'h0, 1'b1, 1'b1, acc);
    for (int i = 0; i < 3; i++) cyc(1'b1, words[4], 1'b0, 1'b1, acc);
    check_eq("early_done_ready", in_ready, 1'b0);
    check_eq("early_done_busy", busy, 1'b1);
    cyc(1'b0, 32'h0, 1'b1, 1'b1, acc);

    // Sign-clamp stimulus
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1'b1, cwords[i], 1'b0, 1'b1, acc);
    cyc(1'b0, 32'h0, 1'b0, 1'b1, acc);
`ifdef MAXNET_LOADER_SIGN_CLAMP_EN
    check_eq("clamp_inp1", inp1, 32'h00000000);
    check_eq("clamp_inp3", inp3, 32'h00000000);
`else
    check_eq("clamp_inp1", inp1, 32'hBF800000);
    check_eq("clamp_inp3", inp3, 32'h80000000);
`endif
    check_eq("clamp_inp2", inp2, 32'h3F800000);
    check_eq("clamp_inp4", inp4, 32'h40000000);
    cyc(1'b0, 32'h0, 1'b1, 1'b1, acc);

    // Random traffic; upstream holds a word until it is accepted
    hv = 1'b0; hd = 32'h0;
    for (int i = 0; i < 3000; i++) begin
      if (!hv) begin
        hv = ($urandom_range(0, 9) < 7);
        hd = $urandom();
      end
      cyc(hv, hd, ($urandom_range(0, 9) < 3), ($urandom_range(0, 99) != 0), acc);
      if (acc) hv = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/maxnet_input_loader.md
MAXNET_INPUT_LOADER -- requirements
Module: maxnet_input_loader

Interface
REQ-001 The block SHALL have no parameters; word width is fixed at 32 bits (IEEE 754 single) and set size is fixed at 4 words.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  synchronous, active-low reset.
REQ-004 in_valid  input  1  upstream word valid.
REQ-005 in_data  input  32  upstream IEEE 754 word.
REQ-006 in_ready  output  1  loader can accept a word this cycle.
REQ-007 done_in  input  1  controller indicates the previous set has been fully processed.
REQ-008 inp1, inp2, inp3, inp4  output  32 each  assembled set, driven to the datapath initial-value registers.
REQ-009 ldI  output  1  one-cycle load strobe for the datapath initial-value registers.
REQ-010 busy  output  1  a set has been issued and is not yet released by done_in.
REQ-011 cnt  output  2  number of words accepted in the current set.

Function
REQ-012 A word SHALL be accepted only on a cycle where in_valid=1 and in_ready=1.
REQ-013 The FSM SHALL have three states: COLLECT, ISSUE and WAIT.
REQ-014 In COLLECT:
- in_ready=1, ldI=0, busy=0.
- An accepted word SHALL be written to slot cnt (0 maps to inp1, 3 maps to inp4), then cnt SHALL increment.
REQ-015 Acceptance while cnt=3 SHALL:
- write inp4;
- wrap cnt to 0;
- move to ISSUE on the next cycle.
REQ-016 In ISSUE:
- ldI=1 for exactly one cycle, in_ready=0, busy=1;
- the FSM SHALL then move unconditionally to WAIT.
REQ-017 In WAIT, in_ready=0, ldI=0 and busy=1; done_in=1 SHALL move the FSM to COLLECT on the next cycle.
REQ-018 done_in SHALL be ignored in COLLECT and ISSUE; a done_in asserted during the ISSUE cycle SHALL NOT release WAIT.
REQ-019 inp1-inp4 SHALL hold their values from the ISSUE cycle until overwritten by a later COLLECT acceptance; slots not yet rewritten keep their old values.
REQ-020 Latency SHALL be: ldI asserted exactly one cycle after the 4th word is accepted, and in_ready reasserted exactly one cycle after done_in is sampled in WAIT.
REQ-021 in_valid while in_ready=0 SHALL leave all state unchanged; the word SHALL NOT be consumed and upstream holds it.
REQ-022 in_data SHALL be stored bit-exact; the block SHALL perform no arithmetic except as stated under Configuration.

Reset
REQ-023 On a clk edge with rst=0, the block SHALL set: state=COLLECT, cnt=0, inp1-inp4=32'h00000000, ldI=0, busy=0.
REQ-024 A reset in any state, including mid-COLLECT or during ISSUE, SHALL discard the partial set and suppress any pending ldI.
REQ-025 While rst=0, in_ready SHALL be 0; in_ready=1 SHALL first appear in the cycle after rst returns to 1.

Configuration
REQ-026 The block SHALL use the macro MAXNET_LOADER_SIGN_CLAMP_EN to compile in or out a sign-clamp feature.
REQ-027 With MAXNET_LOADER_SIGN_CLAMP_EN defined, any accepted word with bit 31 = 1 SHALL be stored as 32'h00000000; this includes -0.0 and negative NaN.
REQ-028 Without the macro, all words SHALL be stored unmodified, and no clamp logic SHALL exist.

Verification
REQ-029 Basic load: words 3F800000, 40000000, 40400000, 40800000 on consecutive cycles, then done_in 3 cycles later:
- ldI high exactly one cycle after the 4th accept;
- inp1-inp4 equal the four words in order;
- busy stays high until one cycle after done_in.
REQ-030 Backpressure: stream five words back-to-back:
- 5th word (41000000) held because in_ready=0;
- it is accepted only after done_in, and appears on inp1.
REQ-031 Gapped input: in_valid toggles 1,0,1,0 with the values above -> cnt steps 1,1,2,2; ldI is not asserted until the 4th accept.
REQ-032 Mid-collect reset: accept 2 words, assert rst=0 for one cycle -> cnt=0, inp1-inp4=0, and no ldI.
REQ-033 Early done_in: assert done_in during the ISSUE cycle only -> FSM stays in WAIT and in_ready stays 0.
REQ-034 Clamp build (MAXNET_LOADER_SIGN_CLAMP_EN defined): load BF800000, 3F800000, 80000000, 40000000 -> inp1=00000000, inp2=3F800000, inp3=00000000, inp4=40000000; the same stimulus without the macro is stored unchanged.
